json_command_sender: RTL and testbench

JSON_COMMAND_SENDER -- requirements
Module: json_command_sender

---
 rtl/json_cmd_pkg.sv | 26 ++
 rtl/uart_tx.sv | 77 +++++++
 rtl/json_command_sender.sv | 92 +++++++++
 tb/tb_json_command_sender.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/json_cmd_pkg.sv
// Shared types and constants for the JSON command sender: FSM states,
// default baud settings and the fixed command message.
package json_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200
    localparam int DEF_BITS_N       = 8;
    localparam int MSG_LEN          = 25;

    // {"T":1,"L":0.5,"R":0.5} CR LF
    localparam logic [7:0] MSG [MSG_LEN] = '{
        8'h7B, 8'h22, 8'h54, 8'h22, 8'h3A, 8'h31, 8'h2C, 8'h22, 8'h4C,
        8'h22, 8'h3A, 8'h30, 8'h2E, 8'h35, 8'h2C, 8'h22, 8'h52, 8'h22,
        8'h3A, 8'h30, 8'h2E, 8'h35, 8'h7D, 8'h0D, 8'h0A
    };

    function automatic logic [7:0] msg_byte(input logic [4:0] i);
        return (int'(i) < MSG_LEN) ? MSG[i] : 8'h00;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BITS_N data bits LSB first, stop bit,
// each held CLKS_PER_BIT cycles. Accepts a byte when data_valid && data_ready.
module uart_tx
    import json_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int BITS_N       = DEF_BITS_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_N-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(BITS_N + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_POS = BW'(BITS_N + 1);

    logic              busy_q, busy_d;
    logic              tx_q, tx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [BITS_N:0]   shf_q, shf_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
            shf_q  <= '1;
        end else begin
            busy_q <= busy_d;
            tx_q   <= tx_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            shf_q  <= shf_d;
        end
    end

    // shf holds the bits still to go after the start bit: data then stop
    always_comb begin
        busy_d = busy_q;
        tx_d   = tx_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        shf_d  = shf_q;
        if (!busy_q) begin
            if (data_valid) begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
                cnt_d  = '0;
                bit_d  = '0;
                shf_d  = {1'b1, data};
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bit_q == STOP_POS) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                tx_d  = shf_q[0];
                shf_d = {1'b1, shf_q[BITS_N:1]};
                bit_d = bit_q + BW'(1);
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign data_ready = ~busy_q;
    assign tx         = tx_q;

endmodule

// File: rtl/json_command_sender.sv
// Sends the fixed JSON command over UART once per valid request and
// raises ready until the requester drops valid.
module json_command_sender
    import json_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int BITS_N       = DEF_BITS_N,
    parameter int NUM_BYTES    = MSG_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              uart_out,
    output logic              ready,
    output logic [BITS_N-1:0] current_byte
);

    localparam int IW = $clog2(NUM_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              data_valid;
    logic              data_ready;
    logic [BITS_N-1:0] data;

    function automatic logic [BITS_N-1:0] byte_at(input logic [IW-1:0] i);
        return BITS_N'(msg_byte(5'(i)));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The next byte is handed over in the cycle the previous stop bit ends,
    // so idx_q always names the byte on the wire.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_valid = 1'b0;
        data       = byte_at(idx_q + IW'(1));
        ready      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data = byte_at('0);
                if (valid && data_ready) begin
                    data_valid = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (data_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d      = idx_q + IW'(1);
                        data_valid = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                ready = 1'b1;
                if (!valid) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign current_byte = byte_at(idx_q);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .BITS_N      (BITS_N)
    ) u_uart_tx (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (uart_out)
    );

endmodule

// File: tb/tb_json_command_sender.sv
// Bench for json_command_sender: reset/idle vector table, then full messages
// decoded from the serial line against a byte scoreboard.
module tb_json_command_sender;

    localparam int CPB    = 8;
    localparam int BN     = 8;
    localparam int NB     = 25;
    localparam int FRAME  = (BN + 2) * CPB;
    localparam int LAT_LO = NB * FRAME;
    localparam int LAT_HI = LAT_LO + 50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic          uart_out;
    logic          ready;
    logic [BN-1:0] current_byte;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int t_valid = 0;

    logic [7:0] exp_msg [NB];
    logic [7:0] msg_q [$];

    json_command_sender #(
        .CLKS_PER_BIT(CPB),
        .BITS_N      (BN),
        .NUM_BYTES   (NB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .uart_out    (uart_out),
        .ready       (ready),
        .current_byte(current_byte)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_msg();
        valid = 1'b1;
        for (int i = 0; i < NB; i++) msg_q.push_back(exp_msg[i]);
        t_valid = cyc;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < LAT_HI + 100) begin
            step();
            n++;
        end
        chk_range({name, "_latency"}, cyc - t_valid, LAT_LO, LAT_HI);
    endtask

    task automatic wait_sb(input int left);
        int n = 0;
        while (msg_q.size() > left && n < NB * FRAME * 2) begin
            step();
            n++;
        end
        chk("wait_sb", 32'(msg_q.size()), 32'(left));
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (uart_out === lvl && n < FRAME * 2) begin
            step();
            n++;
        end
    endtask

    // Serial monitor: checks every cycle of each frame against the expected
    // bit pattern (so bit widths are exact) and decodes mid-bit samples.
    int            mcnt = -1;
    logic          mbad;
    logic [BN-1:0] mexp, mgot;
    logic [BN+1:0] mbits;
    always @(negedge clk) begin
        if (!rst) begin
            mcnt = -1;
            msg_q.delete();
        end else begin
            if (mcnt < 0 && uart_out === 1'b0) begin
                chk("sb_has_byte", 32'(msg_q.size() != 0), 32'd1);
                mexp = (msg_q.size() != 0) ? msg_q[0] : '1;
                chk("current_byte", 32'(current_byte), 32'(mexp));
                mbits = {1'b1, mexp, 1'b0};
                mbad  = 1'b0;
                mgot  = '0;
                mcnt  = 0;
            end
            if (mcnt >= 0) begin
                if (uart_out !== mbits[mcnt / CPB]) mbad = 1'b1;
                if (mcnt % CPB == CPB / 2 && mcnt / CPB >= 1 && mcnt / CPB <= BN)
                    mgot[mcnt / CPB - 1] = uart_out;
                if (mcnt == FRAME - 1) begin
                    if (msg_q.size() != 0) void'(msg_q.pop_front());
                    chk("serial_byte", 32'({mbad, mgot}), 32'(mexp));
                    mcnt = -1;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       valid;
        logic       exp_uart;
        logic       exp_ready;
        logic [7:0] exp_cur;
    } vec_t;

    vec_t tbl [6];

    initial begin
        string s;
        int    r, lo_cnt, hi_bad;
        int    exp_runs [5];

        s = "{\"T\":1,\"L\":0.5,\"R\":0.5}";
        for (int i = 0; i < 23; i++) exp_msg[i] = s[i];
        exp_msg[23] = 8'h0D;
        exp_msg[24] = 8'h0A;

        // reset held with valid toggling, then released with valid low
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h7B};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h7B};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h7B};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h7B};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h7B};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h7B};
        for (int i = 0; i < 6; i++) begin
            rst   = tbl[i].rst;
            valid = tbl[i].valid;
            step();
            chk($sformatf("vec%0d_uart", i), 32'(uart_out), 32'(tbl[i].exp_uart));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
            chk($sformatf("vec%0d_cur", i), 32'(current_byte), 32'(tbl[i].exp_cur));
        end

        // message 1: bit timing of byte 0x7B, latency, then hold valid high
        exp_runs = '{CPB, 2 * CPB, CPB, 4 * CPB, CPB};
        start_msg();
        step();
        for (int i = 0; i < 5; i++) begin
            run_len(i[0] ? 1'b1 : 1'b0, r);
            chk($sformatf("byte0_run%0d", i), 32'(r), 32'(exp_runs[i]));
        end
        run_len(1'b1, r);
        chk_range("byte0_stop_gap", r, CPB, CPB + 2);
        wait_ready("msg1");
        lo_cnt = 0;
        hi_bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (ready !== 1'b1) hi_bad++;
            if (uart_out !== 1'b1) lo_cnt++;
        end
        chk("hold_ready_high", 32'(hi_bad), 32'd0);
        chk("hold_no_start", 32'(lo_cnt), 32'd0);
        chk("msg1_sb_empty", 32'(msg_q.size()), 32'd0);
        valid = 1'b0;
        step();
        chk("msg1_ready_drop", 32'(ready), 32'd0);
        chk("msg1_idle_cur", 32'(current_byte), 32'h7B);

        // message 2: retrigger after one low cycle
        start_msg();
        wait_ready("msg2");
        chk("msg2_sb_empty", 32'(msg_q.size()), 32'd0);
        valid = 1'b0;
        step();
        chk("msg2_ready_drop", 32'(ready), 32'd0);

        // abort during byte 10, then restart from byte 0
        start_msg();
        wait_sb(NB - 10);
        repeat (3 * CPB) step();
        rst   = 1'b0;
        valid = 1'b0;
        step();
        chk("abort_uart", 32'(uart_out), 32'd1);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_cur", 32'(current_byte), 32'h7B);
        rst = 1'b1;
        step();
        chk("abort_idle_uart", 32'(uart_out), 32'd1);
        start_msg();
        wait_ready("restart");
        chk("restart_sb_empty", 32'(msg_q.size()), 32'd0);
        valid = 1'b0;
        step();

        // valid dropped mid-message: whole message still goes out
        start_msg();
        wait_sb(NB - 5);
        valid = 1'b0;
        wait_ready("drop");
        chk("drop_ready_high", 32'(ready), 32'd1);
        step();
        chk("drop_back_idle", 32'(ready), 32'd0);
        chk("drop_sb_empty", 32'(msg_q.size()), 32'd0);
        repeat (2 * FRAME) step();
        chk("final_uart_idle", 32'(uart_out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
